// File: rtl/hippo_decoder_DecoderPkg.sv
// Shared RV32I(+M) decoder definitions.
//   DecodedInstr : registered control bundle produced by the decode stage
//   ImmFmt       : immediate layouts (I, S, B, U, J, SHAMT)
//   gen_imm      : builds the 32-bit immediate for a given format
package hippo_decoder_DecoderPkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {A_RS1, A_ZERO, A_IMM, A_PC} AluASel;
    typedef enum logic [1:0] {B_RS2, B_IMM_EXT, B_PC, B_SHAMT} AluBSel;
    typedef enum logic [2:0] {WB_ALU, WB_MUL, WB_LOAD, WB_PC_PLUS_4, WB_CSR} WbSel;
    typedef enum logic [2:0] {
        BL_BEQ  = 3'b000,
        BL_BNE  = 3'b001,
        BL_BLT  = 3'b100,
        BL_BGE  = 3'b101,
        BL_BLTU = 3'b110,
        BL_BGEU = 3'b111
    } BranchOp;
    typedef enum logic [1:0] {MUL_MUL, MUL_MULH, MUL_MULHSU, MUL_MULHU} MulOp;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT} ImmFmt;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        AluASel      alu_a;
        AluBSel      alu_b;
        WbSel        wb_mux;
        BranchOp     branch_op;
        MulOp        mul_op;
        logic        is_branch;
        logic        is_jump;
        logic        is_load;
        logic        is_store;
        logic        is_csr;
        logic        illegal;
    } DecodedInstr;

    function automatic logic [31:0] gen_imm(logic [31:0] instr, ImmFmt fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm = {instr[31:12], 12'b0};
            IMM_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: imm = {27'b0, instr[24:20]};
            default:   imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/hippo_instr_fifo.sv
// DEPTH-entry show-ahead FIFO of {pc, instr} pairs.
//   clk_i/rst_ni       clock, asynchronous active-low reset
//   flush_i            drops all entries on the edge (dominates push/pop)
//   push_i, push_*_i   write side; ignored while full
//   pop_i              advances the head; ignored while empty
//   head_*_o           current head entry (valid when !empty_o)
//   count_o, empty_o   occupancy
module hippo_instr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [31:0]                push_pc_i,
    input  logic [31:0]                push_instr_i,
    input  logic                       pop_i,
    output logic [31:0]                head_pc_o,
    output logic [31:0]                head_instr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign do_push  = push_i && !full;
    assign do_pop   = pop_i && !empty_o;
    assign count_o  = count_q;
    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];

    // Wrap by comparison so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            pc_mem_q[wr_ptr_q]    <= push_pc_i;
            instr_mem_q[wr_ptr_q] <= push_instr_i;
        end
    end

endmodule

// File: rtl/hippo_decode_queue.sv
// Buffered decode stage between fetch and execute.
//   clk, reset (async, active-low), flush (sync drop of all in-flight work)
//   in_valid/in_ready/in_instr/in_pc   fetch side; in_ready = FIFO not full
//   out_valid/out_ready/out_dec        execute side; out_dec is a registered DecodedInstr
// The FIFO head is decoded combinationally and captured into the output register
// whenever the output stage is empty or being consumed.
module hippo_decode_queue
    import hippo_decoder_DecoderPkg::*;
#(
    parameter int DEPTH = 4,
    parameter bit EN_M  = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [31:0]                     in_instr,
    input  logic [31:0]                     in_pc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$bits(DecodedInstr)-1:0]  out_dec
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_push, fifo_pop;
    logic [31:0]   head_pc, head_instr;
    logic          out_valid_q, out_valid_d;
    DecodedInstr   out_dec_q, out_dec_d;

    assign in_ready  = (fifo_count < CW'(DEPTH));
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = !fifo_empty && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out_dec   = out_dec_q;

    hippo_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk),
        .rst_ni       (reset),
        .flush_i      (flush),
        .push_i       (fifo_push),
        .push_pc_i    (in_pc),
        .push_instr_i (in_instr),
        .pop_i        (fifo_pop),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr),
        .count_o      (fifo_count),
        .empty_o      (fifo_empty)
    );

    function automatic DecodedInstr decode(logic [31:0] instr, logic [31:0] pc);
        DecodedInstr d;
        logic [2:0]  f3;
        f3          = instr[14:12];
        d           = '0;
        d.pc        = pc;
        d.rd        = instr[11:7];
        d.rs1       = instr[19:15];
        d.rs2       = instr[24:20];
        d.alu_a     = A_RS1;
        d.alu_b     = B_RS2;
        d.wb_mux    = WB_ALU;
        d.branch_op = BL_BEQ;
        d.mul_op    = MUL_MUL;
        case (instr[6:0])
            OPC_OP: begin
                if (instr[31:25] == FUNCT7_MULDIV) begin
                    if (EN_M) begin
                        d.wb_mux = WB_MUL;
                        d.mul_op = MulOp'(f3[1:0]);
                    end else begin
                        d.illegal = 1'b1;
                    end
                end
            end
            OPC_OP_IMM: begin
                // SLLI/SRLI/SRAI take the 5-bit shamt instead of the I-immediate.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    d.alu_b = B_SHAMT;
                    d.imm   = gen_imm(instr, IMM_SHAMT);
                end else begin
                    d.alu_b = B_IMM_EXT;
                    d.imm   = gen_imm(instr, IMM_I);
                end
            end
            OPC_LUI: begin
                d.alu_a = A_ZERO;
                d.alu_b = B_IMM_EXT;
                d.imm   = gen_imm(instr, IMM_U);
            end
            OPC_AUIPC: begin
                d.alu_a = A_IMM;
                d.alu_b = B_PC;
                d.imm   = gen_imm(instr, IMM_U);
            end
            OPC_JAL: begin
                d.alu_a   = A_PC;
                d.alu_b   = B_IMM_EXT;
                d.imm     = gen_imm(instr, IMM_J);
                d.wb_mux  = WB_PC_PLUS_4;
                d.is_jump = 1'b1;
            end
            OPC_JALR: begin
                d.alu_b   = B_IMM_EXT;
                d.imm     = gen_imm(instr, IMM_I);
                d.wb_mux  = WB_PC_PLUS_4;
                d.is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                d.imm       = gen_imm(instr, IMM_B);
                d.branch_op = BranchOp'(f3);
                d.is_branch = 1'b1;
                d.illegal   = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                d.alu_b   = B_IMM_EXT;
                d.imm     = gen_imm(instr, IMM_I);
                d.wb_mux  = WB_LOAD;
                d.is_load = 1'b1;
            end
            OPC_STORE: begin
                d.alu_b    = B_IMM_EXT;
                d.imm      = gen_imm(instr, IMM_S);
                d.is_store = 1'b1;
            end
            OPC_SYSTEM: begin
                d.imm = gen_imm(instr, IMM_I);
                if (f3 != 3'b000) begin
                    d.wb_mux = WB_CSR;
                    d.is_csr = 1'b1;
                end
            end
            OPC_MISC_MEM: ;
            default: d.illegal = 1'b1;
        endcase
        // Compressed / non-32-bit encodings are not supported.
        if (instr[1:0] != 2'b11) d.illegal = 1'b1;
        return d;
    endfunction

    always_comb begin
        out_valid_d = out_valid_q;
        out_dec_d   = out_dec_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fifo_pop) begin
            out_valid_d = 1'b1;
            out_dec_d   = decode(head_instr, head_pc);
        end else if (out_ready) begin
            // Bundle consumed with nothing behind it; out_dec keeps its last value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_dec_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_dec_q   <= out_dec_d;
        end
    end

endmodule

// File: tb/tb_hippo_decode_queue.sv
module tb_hippo_decode_queue;
    import hippo_decoder_DecoderPkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = $bits(DecodedInstr);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   in_instr = '0;
    logic [31:0]   in_pc = '0;
    logic          in_ready_m1, in_ready_m0, out_valid_m1, out_valid_m0;
    logic [DW-1:0] out_dec_m1, out_dec_m0;
    DecodedInstr   dec_m1, dec_m0;

    assign dec_m1 = out_dec_m1;
    assign dec_m0 = out_dec_m0;

    hippo_decode_queue #(.DEPTH(DEPTH), .EN_M(1'b1)) dut_m1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_m1), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_m1), .out_ready(out_ready), .out_dec(out_dec_m1)
    );

    hippo_decode_queue #(.DEPTH(DEPTH), .EN_M(1'b0)) dut_m0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_m0), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_m0), .out_ready(out_ready), .out_dec(out_dec_m0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        illegal;
        logic [4:0]  rd, rs1, rs2;
        logic        chk_imm;
        logic [31:0] imm;
        logic        chk_ab;
        logic [1:0]  a, b;
        logic        chk_wb;
        logic [2:0]  wb;
        logic        chk_br;
        logic [2:0]  br;
        logic        chk_mul;
        logic [1:0]  mul;
        logic        isb, isj, isl, iss, isc;
    } exp_t;

    exp_t exp_q1[$];
    exp_t exp_q0[$];
    int   occ = 0;     // words held anywhere in the stage (FIFO + output)
    bit   ov  = 1'b0;  // output register holds a word
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference decode straight from the ISA field definitions, immediates built arithmetically.
    function automatic exp_t ref_decode(logic [31:0] w, logic [31:0] pc, bit en_m);
        exp_t e;
        int   sgn;
        logic [2:0] f3;
        e = '0;
        e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        sgn = w[31] ? -1 : 0;
        f3 = w[14:12];
        case (w[6:0])
            7'b0110011: begin
                e.chk_ab = 1; e.a = A_RS1; e.b = B_RS2; e.chk_wb = 1; e.wb = WB_ALU;
                if (w[31:25] == 7'd1) begin
                    if (en_m) begin e.wb = WB_MUL; e.chk_mul = 1; e.mul = w[13:12]; end
                    else e.illegal = 1;
                end
            end
            7'b0010011: begin
                e.chk_ab = 1; e.a = A_RS1; e.chk_wb = 1; e.wb = WB_ALU; e.chk_imm = 1;
                if (f3 == 3'd1 || f3 == 3'd5) begin e.b = B_SHAMT; e.imm = 32'(w[24:20]); end
                else begin e.b = B_IMM_EXT; e.imm = 32'($signed(w) >>> 20); end
            end
            7'b0110111: begin
                e.chk_ab = 1; e.a = A_ZERO; e.b = B_IMM_EXT; e.chk_wb = 1; e.wb = WB_ALU;
                e.chk_imm = 1; e.imm = w & 32'hFFFFF000;
            end
            7'b0010111: begin
                e.chk_ab = 1; e.a = A_IMM; e.b = B_PC; e.chk_wb = 1; e.wb = WB_ALU;
                e.chk_imm = 1; e.imm = w & 32'hFFFFF000;
            end
            7'b1101111: begin
                e.chk_wb = 1; e.wb = WB_PC_PLUS_4; e.isj = 1; e.chk_imm = 1;
                e.imm = 32'(sgn * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            end
            7'b1100111: begin
                e.chk_wb = 1; e.wb = WB_PC_PLUS_4; e.isj = 1; e.chk_imm = 1;
                e.imm = 32'($signed(w) >>> 20);
            end
            7'b1100011: begin
                e.isb = 1; e.chk_br = 1; e.br = f3; e.chk_imm = 1;
                e.imm = 32'(sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
                if (f3 == 3'd2 || f3 == 3'd3) e.illegal = 1;
            end
            7'b0000011: begin e.isl = 1; e.chk_imm = 1; e.imm = 32'($signed(w) >>> 20); end
            7'b0100011: begin
                e.iss = 1; e.chk_imm = 1;
                e.imm = 32'((($signed(w) >>> 25) * 32) + int'(w[11:7]));
            end
            7'b1110011: if (f3 != 3'd0) begin e.chk_wb = 1; e.wb = WB_CSR; e.isc = 1; end
            7'b0001111: ;
            default: e.illegal = 1;
        endcase
        if (w[1:0] != 2'b11) e.illegal = 1;
        return e;
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic cmp_bundle(string tag, DecodedInstr d, exp_t e);
        cmp({tag, "_pc"}, d.pc, e.pc);
        cmp({tag, "_illegal"}, 32'(d.illegal), 32'(e.illegal));
        if (!e.illegal) begin
            cmp({tag, "_rd"}, 32'(d.rd), 32'(e.rd));
            cmp({tag, "_rs1"}, 32'(d.rs1), 32'(e.rs1));
            cmp({tag, "_rs2"}, 32'(d.rs2), 32'(e.rs2));
            if (e.chk_imm) cmp({tag, "_imm"}, d.imm, e.imm);
            if (e.chk_ab) begin
                cmp({tag, "_alu_a"}, 32'(d.alu_a), 32'(e.a));
                cmp({tag, "_alu_b"}, 32'(d.alu_b), 32'(e.b));
            end
            if (e.chk_wb)  cmp({tag, "_wb"}, 32'(d.wb_mux), 32'(e.wb));
            if (e.chk_br)  cmp({tag, "_branch_op"}, 32'(d.branch_op), 32'(e.br));
            if (e.chk_mul) cmp({tag, "_mul_op"}, 32'(d.mul_op), 32'(e.mul));
            cmp({tag, "_flags"}, 32'({d.is_branch, d.is_jump, d.is_load, d.is_store, d.is_csr}),
                32'({e.isb, e.isj, e.isl, e.iss, e.isc}));
        end
    endtask

    // Reference occupancy model: advances on each clock edge from the driven inputs only.
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            occ = 0; ov = 1'b0;
            exp_q1.delete(); exp_q0.delete();
        end else if (flush) begin
            occ = 0; ov = 1'b0;
            exp_q1.delete(); exp_q0.delete();
        end else begin
            bit fire, pop, push;
            push = in_valid && ((occ - int'(ov)) < DEPTH);
            fire = ov && out_ready;
            pop  = ((occ - int'(ov)) > 0) && (!ov || out_ready);
            if (fire) occ--;
            if (push) begin
                occ++;
                exp_q1.push_back(ref_decode(in_instr, in_pc, 1'b1));
                exp_q0.push_back(ref_decode(in_instr, in_pc, 1'b0));
            end
            if (pop) ov = 1'b1;
            else if (fire) ov = 1'b0;
        end
    end

    // Monitor: handshake levels every cycle, bundle whenever execute takes one.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            cmp("in_ready", 32'(in_ready_m1), 32'((occ - int'(ov)) < DEPTH));
            cmp("in_ready_m0", 32'(in_ready_m0), 32'((occ - int'(ov)) < DEPTH));
            cmp("out_valid", 32'(out_valid_m1), 32'(ov));
            cmp("out_valid_m0", 32'(out_valid_m0), 32'(ov));
            if (out_valid_m1 && out_ready && !flush) begin
                if (exp_q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_output: got pc %h expected no word", dec_m1.pc);
                end else begin
                    exp_t e1, e0;
                    e1 = exp_q1.pop_front();
                    e0 = exp_q0.pop_front();
                    cmp_bundle("m1", dec_m1, e1);
                    cmp_bundle("m0", dec_m0, e0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Push one word into an idle stage, leave it in the output register.
    task automatic load_one(logic [31:0] w, logic [31:0] pc);
        in_valid = 1'b1; in_instr = w; in_pc = pc;
        step();
        in_valid = 1'b0;
        cmp("latency_not_early", 32'(out_valid_m1), 32'd0);
        step();
        cmp("latency_valid", 32'(out_valid_m1), 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 12))
            0:  w[6:0] = 7'b0110011;
            1:  w[6:0] = 7'b0010011;
            2:  w[6:0] = 7'b0110111;
            3:  w[6:0] = 7'b0010111;
            4:  w[6:0] = 7'b1101111;
            5:  w[6:0] = 7'b1100111;
            6:  w[6:0] = 7'b1100011;
            7:  w[6:0] = 7'b0000011;
            8:  w[6:0] = 7'b0100011;
            9:  w[6:0] = 7'b1110011;
            10: w[6:0] = 7'b0001111;
            default: ;
        endcase
        if (w[6:0] == 7'b0110011) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'd1 : 7'd0;
        return w;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        cmp("reset_out_dec_zero", 32'(out_dec_m1 == '0), 32'd1);
        cmp("reset_in_ready", 32'(in_ready_m1), 32'd1);

        // addi x1,x0,5
        load_one(32'h00500093, 32'h0000_1000);
        cmp("addi_rd", 32'(dec_m1.rd), 32'd1);
        cmp("addi_rs1", 32'(dec_m1.rs1), 32'd0);
        cmp("addi_imm", dec_m1.imm, 32'h0000_0005);
        cmp("addi_alu_a", 32'(dec_m1.alu_a), 32'(A_RS1));
        cmp("addi_alu_b", 32'(dec_m1.alu_b), 32'(B_IMM_EXT));
        cmp("addi_wb", 32'(dec_m1.wb_mux), 32'(WB_ALU));
        cmp("addi_illegal", 32'(dec_m1.illegal), 32'd0);
        consume();

        // beq x1,x2,-4
        load_one(32'hFE208EE3, 32'h0000_1004);
        cmp("beq_imm", dec_m1.imm, 32'hFFFF_FFFC);
        cmp("beq_op", 32'(dec_m1.branch_op), 32'(BL_BEQ));
        cmp("beq_is_branch", 32'(dec_m1.is_branch), 32'd1);
        cmp("beq_rs1", 32'(dec_m1.rs1), 32'd1);
        cmp("beq_rs2", 32'(dec_m1.rs2), 32'd2);
        consume();

        // mul x3,x1,x2 with and without the M extension
        load_one(32'h022081B3, 32'h0000_1008);
        cmp("mul_wb", 32'(dec_m1.wb_mux), 32'(WB_MUL));
        cmp("mul_op", 32'(dec_m1.mul_op), 32'(MUL_MUL));
        cmp("mul_illegal_en0", 32'(dec_m0.illegal), 32'd1);
        consume();

        // Fill with execute stalled: DEPTH in FIFO plus one in the output register.
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_valid = 1'b1; in_instr = 32'h00000093 | (32'(i) << 20); in_pc = 32'h2000 + 32'(i * 4);
            step();
        end
        in_valid = 1'b0;
        cmp("full_in_ready", 32'(in_ready_m1), 32'd0);
        out_ready = 1'b1;
        step();
        cmp("drain_in_ready", 32'(in_ready_m1), 32'd1);
        repeat (DEPTH + 2) step();
        out_ready = 1'b0;

        // Flush a full stage while fetch is still offering a word.
        for (int i = 0; i < DEPTH + 1; i++) begin
            in_valid = 1'b1; in_instr = 32'h00100113; in_pc = 32'h3000 + 32'(i * 4);
            step();
        end
        flush = 1'b1; in_instr = 32'h00200113; in_pc = 32'h3100;
        step();
        flush = 1'b0; in_valid = 1'b0;
        cmp("flush_out_valid", 32'(out_valid_m1), 32'd0);
        cmp("flush_in_ready", 32'(in_ready_m1), 32'd1);
        load_one(32'h00300113, 32'h0000_3200);
        cmp("post_flush_pc", dec_m1.pc, 32'h0000_3200);
        consume();

        // Reset mid-stream with three words in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = 32'h00400193; in_pc = 32'h4000 + 32'(i * 4);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        cmp("async_reset_out_valid", 32'(out_valid_m1), 32'd0);
        cmp("async_reset_out_dec", 32'(out_dec_m1 == '0), 32'd1);
        repeat (2) step();
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        cmp("no_stale_word", 32'(out_valid_m1), 32'd0);
        out_ready = 1'b0;
        load_one(32'h0000_0000, 32'h0000_5000);
        cmp("zero_word_illegal", 32'(dec_m1.illegal), 32'd1);
        consume();

        // Randomized traffic with varying backpressure and occasional flushes.
        for (int blk = 0; blk < 15; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(10, 100);
            for (int c = 0; c < 200; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(1, 100) <= rdy_pct);
                flush     = ($urandom_range(0, 49) == 0);
                in_instr  = rand_instr();
                in_pc     = in_pc + 32'd4;
                step();
            end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (DEPTH + 4) step();
        cmp("scoreboard_drained", 32'(exp_q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
